// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
//   MUL_UU / MUL_SS / MUL_SU : operand signedness modes (2'b11 behaves as MUL_UU)
//   mul_state_e              : controller states IDLE -> RUN -> FIX
package mul_pkg;

  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_SS = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_abs.sv
// Combinational two's-complement magnitude.
//   val       : operand
//   is_signed : operand is to be interpreted as signed
//   magnitude : |val| when signed and negative, else val unchanged
// The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
module mul_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             is_signed,
  output logic [WIDTH-1:0] magnitude
);

  always_comb begin
    magnitude = val;
    if (is_signed && val[WIDTH-1]) begin
      magnitude = ~val + 1'b1;
    end
  end

endmodule

// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while busy is low
//   mode       : 00 unsigned, 01 signed x signed, 10 signed a x unsigned b, 11 as 00
//   a, b       : operands, sampled only on accept
//   busy       : operation in flight (low again in the done cycle)
//   done       : one-cycle pulse, res valid
//   res        : 2*WIDTH product, held until the next done
// Operands are reduced to magnitudes on accept, multiplied unsigned, and the
// sign is reapplied in FIX. Latency is WIDTH+1 edges from accept to done.
module seq_multiplier_param
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] res_q;

  logic               a_signed;
  logic               b_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   addend_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] res_d;

  assign a_signed = (mode == MUL_SS) || (mode == MUL_SU);
  assign b_signed = (mode == MUL_SS);

  mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val       (a),
    .is_signed (a_signed),
    .magnitude (mag_a)
  );

  mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val       (b),
    .is_signed (b_signed),
    .magnitude (mag_b)
  );

  // The W+1-bit partial sum keeps its carry, which becomes the new MSB
  // once the accumulator shifts right.
  always_comb begin
    addend_d = '0;
    if (acc_q[0]) begin
      addend_d = mcand_q;
    end
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_d};
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
    res_d = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            neg_q   <= (a_signed & a[WIDTH-1]) ^ (b_signed & b[WIDTH-1]);
            mcand_q <= mag_a;
            acc_q   <= {{WIDTH{1'b0}}, mag_b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          res_q   <= res_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule
